// File: rtl/tiny16_loader_pkg.sv
// Shared types and constants for the tiny16 serial program loader.
package tiny16_loader_pkg;

  // Frame parser states.
  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StDataHi,
    StDataLo,
    StCsum,
    StDone,
    StErr
  } load_state_e;

  // UART receiver states.
  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_IDX_W = 3;   // selects one of the 8 data bits
  localparam int unsigned LEN_W     = 16;  // image length field

endpackage

// File: rtl/tiny16_loader_if.sv
// Memory-write and status bundle between the loader and the tiny16 core/memory.
interface tiny16_loader_if #(
  parameter int unsigned ADDR_W = 16
) ();

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic              cpu_rst;
  logic              done;
  logic              err;

  modport master (
    output mem_we, mem_addr, mem_data, cpu_rst, done, err
  );

  modport slave (
    input mem_we, mem_addr, mem_data, cpu_rst, done, err
  );

endinterface

// File: rtl/tiny16_uart_rx.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling timer, LSB-first shifter.
module tiny16_uart_rx
  import tiny16_loader_pkg::*;
#(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rx_i,
  output logic              byte_valid_o,
  output logic [BYTE_W-1:0] byte_data_o,
  output logic              byte_ferr_o
);

  localparam int unsigned   CntW    = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] FullCnt = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] HalfCnt = CntW'(CLK_DIV / 2 - 1);

  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  logic                 fall;
  rx_state_e            state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [BYTE_W-1:0]    shift_q, shift_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;

  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign fall = rx_prev_q & ~rx_sync_q;

  // Receiver state and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RxIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  // Bit timing: half a bit to the start-bit centre, then a full bit per sample.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    valid_d   = 1'b0;
    ferr_d    = ferr_q;
    unique case (state_q)
      RxIdle: begin
        if (fall) begin
          state_d = RxStart;
          cnt_d   = HalfCnt;
        end
      end
      RxStart: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (!rx_sync_q) begin
          state_d   = RxData;
          cnt_d     = FullCnt;
          bit_idx_d = '0;
        end else begin
          state_d = RxIdle;  // line went high again: treat as a glitch
        end
      end
      RxData: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          shift_d = {rx_sync_q, shift_q[BYTE_W-1:1]};
          cnt_d   = FullCnt;
          if (bit_idx_q == BIT_IDX_W'(BYTE_W - 1)) begin
            state_d = RxStop;
          end else begin
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
          end
        end
      end
      RxStop: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          valid_d = 1'b1;
          ferr_d  = ~rx_sync_q;
          state_d = RxIdle;
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  assign byte_valid_o = valid_q;
  assign byte_data_o  = shift_q;
  assign byte_ferr_o  = ferr_q;

endmodule

// File: rtl/tiny16_loader.sv
// tiny16 serial program loader: parses A5/LEN/words[/checksum] frames from the
// UART and writes the image into program memory, holding the core in reset
// until a complete image has arrived.
// Build option: define LOADER_CHECKSUM_EN to expect and verify a trailing XOR
// checksum byte; without it the last data word completes the load.
module tiny16_loader
  import tiny16_loader_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 16,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rx_i,
  tiny16_loader_if.master  bus
);

  localparam logic [LEN_W:0] MaxWords = (LEN_W + 1)'(MAX_WORDS);
`ifdef LOADER_CHECKSUM_EN
  localparam load_state_e AfterData = StCsum;
`else
  localparam load_state_e AfterData = StDone;
`endif

  logic              byte_valid, byte_ferr, byte_ok, byte_bad;
  logic [BYTE_W-1:0] byte_data;

  load_state_e       state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  cnt_inc;
  logic [LEN_W-1:0]  len_rx;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic [BYTE_W-1:0] csum_q, csum_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cpu_rst_q, cpu_rst_d;

  tiny16_uart_rx #(
    .CLK_DIV (CLK_DIV)
  ) u_uart_rx (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rx_i         (rx_i),
    .byte_valid_o (byte_valid),
    .byte_data_o  (byte_data),
    .byte_ferr_o  (byte_ferr)
  );

  assign byte_ok  = byte_valid & ~byte_ferr;
  assign byte_bad = byte_valid & byte_ferr;
  assign cnt_inc  = cnt_q + LEN_W'(1);
  assign len_rx   = {hi_q, byte_data};

  // Parser state, word assembly and registered status outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      len_q     <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      csum_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      csum_q    <= csum_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  // Frame parsing; status outputs follow the next state so they change with it.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    csum_d  = csum_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;

    // Address advances in the cycle after each write strobe.
    if (we_q) begin
      addr_d = addr_q + ADDR_W'(1);
    end

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (byte_ok && byte_data == SYNC_BYTE) begin
          state_d = StLenHi;
          csum_d  = '0;
          addr_d  = '0;
          cnt_d   = '0;
        end
      end
      StLenHi: begin
        if (byte_ok) begin
          hi_d    = byte_data;
          state_d = StLenLo;
        end
      end
      StLenLo: begin
        if (byte_ok) begin
          len_d = len_rx;
          if (len_rx == '0) begin
            state_d = AfterData;
          end else if ({1'b0, len_rx} > MaxWords) begin
            state_d = StErr;
          end else begin
            state_d = StDataHi;
          end
        end
      end
      StDataHi: begin
        if (byte_ok) begin
          hi_d    = byte_data;
          csum_d  = csum_q ^ byte_data;
          state_d = StDataLo;
        end
      end
      StDataLo: begin
        if (byte_ok) begin
          we_d    = 1'b1;
          wdata_d = {hi_q, byte_data};
          csum_d  = csum_q ^ byte_data;
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == len_q) ? AfterData : StDataHi;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCsum: begin
        if (byte_ok) begin
          state_d = (byte_data == csum_q) ? StDone : StErr;
        end
      end
`endif
      default: state_d = state_q;
    endcase

    // A bad stop bit inside a frame kills the load; between frames it is noise.
    if (byte_bad && !(state_q inside {StIdle, StDone, StErr})) begin
      state_d = StErr;
    end
  end

  // Status decode from the next state keeps outputs glitch-free and aligned.
  always_comb begin
    done_d    = (state_d == StDone);
    err_d     = (state_d == StErr);
    cpu_rst_d = (state_d != StDone);
  end

  assign bus.mem_we   = we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_data = wdata_q;
  assign bus.cpu_rst  = cpu_rst_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule
